seq_array_mult: RTL and testbench
=================================

# seq_array_mult

Parametrised iterative shift-and-add multiplier that computes a WIDTH×WIDTH product over WIDTH+1 clock cycles, with a signed (two's-complement) or unsigned mode selected per operation. It uses valid/ready handshakes on both its input and output sides. It is the sequential successor to the fixed 4×4 combinational array multiplier: it trades throughput for area, reuses one WIDTH-bit adder built from the existing half- and full-adder cells, and drops into datapaths that need a multiply of arbitrary width.

## Interface
- WIDTH, 4, operand width in bits; must be ≥ 2; product width is 2*WIDTH
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands a, b and signed_mode are valid
- in_ready  out  1  block accepts operands this cycle; high only in IDLE
- a  in  WIDTH  multiplicand
- b  in  WIDTH  multiplier
- signed_mode  in  1  1 = operands and product are two's complement; 0 = unsigned
- out_valid  out  1  product is valid; high only in DONE
- out_ready  in  1  consumer takes product this cycle
- product  out  2*WIDTH  result, held stable while out_valid=1
- busy  out  1  high in RUN and FIXUP

## Operation
- States: IDLE, RUN, FIXUP, DONE.
- IDLE: in_ready=1. On in_valid=1:
  - Latch |a| and |b| as WIDTH-bit magnitudes. In signed mode, negative operands are negated; the most negative value maps to 2^(WIDTH-1), which is representable.
  - Latch neg = signed_mode & (a[MSB] ^ b[MSB]).
  - Clear the accumulator, load the bit counter with WIDTH, go to RUN.
- RUN: one multiplier bit per cycle, LSB first.
  - If the current bit is 1, add the multiplicand to the upper WIDTH bits of the accumulator, carry included.
  - Shift the {carry, accumulator} pair right by 1 and decrement the counter.
  - When the counter reaches 0, go to FIXUP.
- FIXUP: if neg=1, the accumulator becomes its 2*WIDTH-bit two's complement; otherwise it is unchanged. Go to DONE.
- DONE: out_valid=1 and product=accumulator. On out_ready=1, go to IDLE.
- in_valid outside IDLE is ignored; no operand is captured and no error is raised.
- a, b and signed_mode are sampled only on the accept edge. Later changes do not affect the operation in flight.
- Result range:
  - Unsigned: 0..(2^WIDTH−1)^2.
  - Signed: (−2^(WIDTH−1))^2 = 2^(2WIDTH−2) fits, so no overflow is possible in either mode.
- Zero operand: same latency; product=0; neg is suppressed when the magnitude result is zero, so the product is never −0.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert) gives state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, accumulator and counter=0.
- Reset asserted mid-operation aborts it immediately; no product is emitted.
- Accept on edge k → RUN on edges k+1..k+WIDTH → FIXUP on edge k+WIDTH+1.
- out_valid is high from edge k+WIDTH+1 until the edge where out_ready=1. Latency is WIDTH+1 edges.
- The earliest next accept is the edge after the output handshake. Minimum initiation interval is WIDTH+2 cycles.
- in_ready and out_valid are registered-state decodes with no combinational path from in_valid or out_ready.
- out_ready held low keeps the block in DONE indefinitely with product stable.

## Structure
- Shared package/include mult_defs holds:
  - the 2-bit state encoding (IDLE=0, RUN=1, FIXUP=2, DONE=3);
  - localparam CNT_W = $clog2(WIDTH+1).
- One sub-module, rc_adder: a WIDTH-parameterised ripple-carry adder (a, b, cin → sum, cout) generated from the existing half- and full-adder cells.
- The top level owns the FSM, operand registers, accumulator, counter and negation logic.

## Test plan
- WIDTH=4, unsigned, a=15, b=15, out_ready=1 → out_valid on 5th edge after accept, product=8'hE1 (225); in_ready low for 6 cycles.
- WIDTH=4, signed, a=4'h8, b=4'h8 → product=8'h40 (64); a=4'hD (−3), b=4'h5 → product=8'hF1 (−15); a=0, b=4'hF → product=0 with neg suppressed.
- Backpressure: WIDTH=4, a=7, b=9, out_ready low for 3 cycles after out_valid → product=8'h3F held stable; in_valid pulses during RUN and DONE are ignored; next accept is only after the handshake.
- Reset mid-RUN: rst_n pulled low 2 cycles after accept → all outputs at reset values immediately; after release, a=3, b=5 gives product=15 with normal latency.
- WIDTH=8 random regression, ≥1000 operations each mode with random in_valid/out_ready → every product matches a*b (signed/unsigned reference); every accepted operation produces exactly one output.

Source files
------------

// File: rtl/seq_array_mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM state encoding and counter sizing helper.
package seq_array_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Counter must hold the value WIDTH itself, hence WIDTH+1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_array_mult_if.sv
// Operand/product valid-ready bundle for seq_array_mult.
interface seq_array_mult_if #(
  parameter int WIDTH = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   signed_mode;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH-1:0]     product;
  logic                   busy;

  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/seq_array_mult_rc_adder.sv
// Ripple-carry adder built from half/full adder cells; the full adder is
// itself two half adders plus an OR on the carries.
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b;
  assign cout = a & b;
endmodule

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic s0, c0, c1;

  half_adder u_ha0 (.a(a),  .b(b),   .sum(s0),  .cout(c0));
  half_adder u_ha1 (.a(s0), .b(cin), .sum(sum), .cout(c1));

  assign cout = c0 | c1;
endmodule

module rc_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      full_adder u_fa (
        .a    (a[gi]),
        .b    (b[gi]),
        .cin  (carry[gi]),
        .sum  (sum[gi]),
        .cout (carry[gi+1])
      );
    end
  endgenerate

  assign cout = carry[WIDTH];
endmodule

// File: rtl/seq_array_mult.sv
// Iterative WIDTH x WIDTH multiplier: magnitudes are multiplied LSB-first
// over WIDTH cycles, then the sign is applied in a single fixup cycle.
module seq_array_mult
  import seq_array_mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  seq_array_mult_if.slave  bus
);
  localparam int CNT_W = cnt_width(WIDTH);
  localparam int PW    = 2 * WIDTH;

  state_t           state_reg,  state_next;
  logic [WIDTH-1:0] mcand_reg,  mcand_next;
  logic [WIDTH-1:0] mplier_reg, mplier_next;
  logic [PW-1:0]    acc_reg,    acc_next;
  logic [CNT_W-1:0] cnt_reg,    cnt_next;
  logic             neg_reg,    neg_next;

  logic [WIDTH-1:0] a_mag, b_mag, addend, sum;
  logic             cout;

  // Most negative input negates to 2^(WIDTH-1), which is still a valid
  // unsigned WIDTH-bit magnitude.
  assign a_mag  = (bus.signed_mode && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
  assign b_mag  = (bus.signed_mode && bus.b[WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;
  assign addend = mplier_reg[0] ? mcand_reg : '0;

  rc_adder #(.WIDTH(WIDTH)) u_adder (
    .a    (acc_reg[PW-1:WIDTH]),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  always_comb begin
    state_next  = state_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    acc_next    = acc_reg;
    cnt_next    = cnt_reg;
    neg_next    = neg_reg;

    case (state_reg)
      ST_IDLE: begin
        if (bus.in_valid) begin
          mcand_next  = a_mag;
          mplier_next = b_mag;
          neg_next    = bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          acc_next    = '0;
          cnt_next    = CNT_W'(WIDTH);
          state_next  = ST_RUN;
        end
      end
      ST_RUN: begin
        // Partial sum lands in the upper half; the carry-out becomes the new MSB.
        acc_next    = {cout, sum, acc_reg[WIDTH-1:1]};
        mplier_next = mplier_reg >> 1;
        cnt_next    = cnt_reg - 1'b1;
        if (cnt_reg == CNT_W'(1)) begin
          state_next = ST_FIXUP;
        end
      end
      ST_FIXUP: begin
        if (neg_reg && (acc_reg != '0)) begin
          acc_next = ~acc_reg + 1'b1;
        end
        state_next = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      neg_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      acc_reg    <= acc_next;
      cnt_reg    <= cnt_next;
      neg_reg    <= neg_next;
    end
  end

  assign bus.in_ready  = (state_reg == ST_IDLE);
  assign bus.out_valid = (state_reg == ST_DONE);
  assign bus.busy      = (state_reg == ST_RUN) || (state_reg == ST_FIXUP);
  assign bus.product   = acc_reg;

endmodule

// File: tb/tb_seq_array_mult.sv
// Bench for seq_array_mult: directed WIDTH=4 cases plus a randomized
// WIDTH=8 regression scored against plain integer multiplication.
module tb_seq_array_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst4_n;
  logic rst8_n;

  seq_array_mult_if #(.WIDTH(4)) if4 ();
  seq_array_mult_if #(.WIDTH(8)) if8 ();

  seq_array_mult #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst4_n), .bus(if4.slave));
  seq_array_mult #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst8_n), .bus(if8.slave));

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference product: interpret operands as integers and multiply.
  function automatic logic [15:0] ref_mul(input int w, input logic [7:0] a,
                                          input logic [7:0] b, input logic sm);
    int av, bv, p;
    logic [31:0] pu;
    av = int'(a);
    bv = int'(b);
    if (sm && a[w-1]) av = av - (1 << w);
    if (sm && b[w-1]) bv = bv - (1 << w);
    p  = av * bv;
    pu = p;
    return (w == 4) ? (pu[15:0] & 16'h00FF) : pu[15:0];
  endfunction

  // One WIDTH=4 operation with out_ready held high; checks latency,
  // in_ready low time and product.
  task automatic do_op4(input logic [3:0] a, input logic [3:0] b, input logic sm,
                        input logic [7:0] exp, input string tag);
    int n, lat, low;
    bit seen;
    logic [7:0] prod;
    n = 0;
    while (!if4.in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_ready"}, 64'(if4.in_ready), 64'd1);
    if4.a = a; if4.b = b; if4.signed_mode = sm;
    if4.in_valid = 1'b1; if4.out_ready = 1'b1;
    @(posedge clk); #1;
    if4.in_valid = 1'b0;
    if4.a = ~a; if4.b = a ^ b; if4.signed_mode = ~sm;
    n = 0; lat = 0; low = 0; seen = 0; prod = '0;
    while (n < 50) begin
      if (if4.in_ready) break;
      low++;
      if (if4.out_valid && !seen) begin
        seen = 1; lat = n; prod = if4.product;
      end
      @(posedge clk); #1; n++;
    end
    check({tag, "_lat"},  64'(lat),  64'd5);
    check({tag, "_busy"}, 64'(low),  64'd6);
    check({tag, "_prod"}, 64'(prod), 64'(exp));
    $display("w4 %s a=%h b=%h signed=%0d product=%h lat=%0d", tag, a, b, sm, prod, lat);
  endtask

  initial begin
    logic [15:0] expq[$];
    logic [15:0] exp16, p16;
    logic [7:0]  a8, b8;
    int n, acc_m, outs_m, cyc;
    bit do_acc, do_out, any_valid;

    rst4_n = 1'b0; rst8_n = 1'b0;
    if4.in_valid = 1'b0; if4.out_ready = 1'b1; if4.a = '0; if4.b = '0; if4.signed_mode = 1'b0;
    if8.in_valid = 1'b0; if8.out_ready = 1'b0; if8.a = '0; if8.b = '0; if8.signed_mode = 1'b0;

    #2;
    check("rst_in_ready",  64'(if4.in_ready),  64'd1);
    check("rst_out_valid", 64'(if4.out_valid), 64'd0);
    check("rst_busy",      64'(if4.busy),      64'd0);
    check("rst_product",   64'(if4.product),   64'd0);
    @(posedge clk); #1;
    rst4_n = 1'b1; rst8_n = 1'b1;
    @(posedge clk); #1;

    do_op4(4'hF, 4'hF, 1'b0, 8'hE1, "u15x15");
    do_op4(4'h8, 4'h8, 1'b1, 8'h40, "s_min_sq");
    do_op4(4'hD, 4'h5, 1'b1, 8'hF1, "s_m3x5");
    do_op4(4'h0, 4'hF, 1'b1, 8'h00, "s_zero");
    do_op4(4'h7, 4'h8, 1'b1, 8'hC8, "s_7xm8");

    // Backpressure with ignored in_valid pulses in RUN and DONE
    if4.out_ready = 1'b0;
    if4.a = 4'd7; if4.b = 4'd9; if4.signed_mode = 1'b0; if4.in_valid = 1'b1;
    @(posedge clk); #1;
    if4.in_valid = 1'b0;
    @(posedge clk); #1;
    if4.in_valid = 1'b1; if4.a = 4'd1; if4.b = 4'd1;
    @(posedge clk); #1;
    check("bp_run_ignore", 64'(if4.in_ready), 64'd0);
    if4.in_valid = 1'b0;
    n = 0;
    while (!if4.out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("bp_valid", 64'(if4.out_valid), 64'd1);
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_prod",  64'(if4.product),   64'h3F);
      check("bp_hold_valid", 64'(if4.out_valid), 64'd1);
      check("bp_hold_ready", 64'(if4.in_ready),  64'd0);
      if4.in_valid = 1'b1; if4.a = 4'd2; if4.b = 4'd2;
      @(posedge clk); #1;
    end
    if4.in_valid = 1'b0;
    check("bp_final_prod", 64'(if4.product), 64'h3F);
    $display("w4 bp a=7 b=9 product=%h", if4.product);
    if4.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_post_valid", 64'(if4.out_valid), 64'd0);
    check("bp_post_ready", 64'(if4.in_ready),  64'd1);

    // Reset two cycles into RUN
    if4.a = 4'hF; if4.b = 4'hF; if4.signed_mode = 1'b0; if4.in_valid = 1'b1;
    @(posedge clk); #1;
    if4.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_busy", 64'(if4.busy), 64'd1);
    rst4_n = 1'b0;
    #1;
    check("mid_rst_ready",   64'(if4.in_ready),  64'd1);
    check("mid_rst_valid",   64'(if4.out_valid), 64'd0);
    check("mid_rst_busy",    64'(if4.busy),      64'd0);
    check("mid_rst_product", 64'(if4.product),   64'd0);
    @(posedge clk); #1;
    rst4_n = 1'b1;
    any_valid = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (if4.out_valid) any_valid = 1;
    end
    check("mid_no_output", 64'(any_valid), 64'd0);
    do_op4(4'd3, 4'd5, 1'b0, 8'd15, "after_rst");

    // WIDTH=8 random regression, unsigned then signed
    for (int mode = 0; mode < 2; mode++) begin
      if8.signed_mode = mode[0];
      acc_m = 0; outs_m = 0; cyc = 0;
      while (outs_m < 1000 && cyc < 40000) begin
        a8 = 8'($urandom); b8 = 8'($urandom);
        if8.a = a8; if8.b = b8;
        if8.in_valid  = (acc_m < 1000) && ($urandom_range(0, 3) != 0);
        if8.out_ready = ($urandom_range(0, 3) != 0);
        do_acc = if8.in_valid && if8.in_ready;
        do_out = if8.out_valid && if8.out_ready;
        p16 = if8.product;
        if (do_acc) expq.push_back(ref_mul(8, a8, b8, mode[0]));
        @(posedge clk); #1;
        cyc++;
        if (do_acc) acc_m++;
        if (do_out) begin
          if (expq.size() == 0) begin
            check("r8_spurious", 64'd1, 64'd0);
          end else begin
            exp16 = expq.pop_front();
            check("r8_prod", 64'(p16), 64'(exp16));
          end
          $display("w8 mode=%0d op=%0d product=%h", mode, outs_m, p16);
          outs_m++;
        end
      end
      if8.in_valid = 1'b0;
      check("r8_out_count", 64'(outs_m), 64'd1000);
      check("r8_pending",   64'(expq.size()), 64'd0);
      expq.delete();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
